// File: rtl/keypad_pkg.sv
// Shared types, constants and encoding helpers for the matrix-keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StValid,
    StRelease
  } state_e;

  localparam int unsigned DWELL   = 3;
  localparam int unsigned DWELL_W = $clog2(DWELL);
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned IDX_W   = 3;

  // Index of the lowest set bit; also decodes a one-hot column vector.
  function automatic logic [IDX_W-1:0] lsb_index(input logic [7:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parametrised-width two-flop synchroniser for asynchronous level inputs.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning keypad controller: debounces press and release, encodes the key
// and hands it downstream over a valid/ready handshake, one event per press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned ROWS            = 4,
  parameter int unsigned COLS            = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic                          slow_clk,
  input  logic                          rst_n,
  input  logic [ROWS-1:0]               row_in,
  output logic [COLS-1:0]               col_out,
  output logic [$clog2(ROWS*COLS)-1:0]  key_code,
  output logic                          key_valid,
  input  logic                          key_ready,
  output logic                          key_multi,
  output logic                          key_held
);

  localparam int unsigned KW = $clog2(ROWS * COLS);
  localparam logic [CNT_W-1:0]   DebCnt    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [DWELL_W-1:0] DwellLast = DWELL_W'(DWELL - 1);

  logic [ROWS-1:0] rs;

  sync_2ff #(
    .WIDTH (ROWS)
  ) u_sync (
    .clk_i  (slow_clk),
    .rst_ni (rst_n),
    .d_i    (row_in),
    .q_o    (rs)
  );

  state_e             state_q, state_d;
  logic [COLS-1:0]    col_q, col_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROWS-1:0]    row_lat_q, row_lat_d;
  logic [KW-1:0]      code_q, code_d;
  logic               multi_q, multi_d;
  logic               valid_q, valid_d;
  logic               held_q, held_d;

  logic               dwell_end;
  logic               rs_any;
  logic [COLS-1:0]    col_next;
  logic [CNT_W-1:0]   cnt_inc;
  logic [7:0]         lat_ext;
  logic [7:0]         col_ext;
  logic [KW-1:0]      code_enc;
  logic               multi_enc;

  assign dwell_end = (dwell_q == DwellLast);
  assign rs_any    = |rs;
  assign col_next  = {col_q[COLS-2:0], col_q[COLS-1]};
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

  // Encoder works on the latched pattern and the held column, both stable in DEBOUNCE.
  assign lat_ext   = 8'(row_lat_q);
  assign col_ext   = 8'(col_q);
  assign code_enc  = KW'(32'(lsb_index(lat_ext)) * COLS + 32'(lsb_index(col_ext)));
  assign multi_enc = (popcount8(lat_ext) > 4'd1);

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    dwell_d   = dwell_q;
    cnt_d     = cnt_q;
    row_lat_d = row_lat_q;
    code_d    = code_q;
    multi_d   = multi_q;

    unique case (state_q)
      StScan: begin
        if (dwell_end) begin
          dwell_d = '0;
          if (rs_any) begin
            row_lat_d = rs;
            cnt_d     = CNT_W'(1);
            state_d   = StDebounce;
          end else begin
            col_d = col_next;
          end
        end else begin
          dwell_d = dwell_q + DWELL_W'(1);
        end
      end

      StDebounce: begin
        // The count already includes the latching sample, so no compare on the final step.
        if (cnt_q >= DebCnt) begin
          state_d = StValid;
          code_d  = code_enc;
          multi_d = multi_enc;
        end else if (rs == row_lat_q) begin
          cnt_d = cnt_inc;
        end else begin
          state_d = StScan;
          col_d   = col_next;
          dwell_d = '0;
          cnt_d   = '0;
        end
      end

      StValid: begin
        if (key_ready) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end

      StRelease: begin
        if (rs_any) begin
          cnt_d = '0;
        end else if (cnt_inc >= DebCnt) begin
          state_d = StScan;
          col_d   = col_next;
          dwell_d = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        state_d = StScan;
      end
    endcase

    valid_d = (state_d == StValid);
    held_d  = (state_d == StValid) || (state_d == StRelease);
  end

  always_ff @(posedge slow_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StScan;
      col_q     <= COLS'(1);
      dwell_q   <= '0;
      cnt_q     <= '0;
      row_lat_q <= '0;
      code_q    <= '0;
      multi_q   <= 1'b0;
      valid_q   <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      dwell_q   <= dwell_d;
      cnt_q     <= cnt_d;
      row_lat_q <= row_lat_d;
      code_q    <= code_d;
      multi_q   <= multi_d;
      valid_q   <= valid_d;
      held_q    <= held_d;
    end
  end

  assign col_out   = col_q;
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_multi = multi_q;
  assign key_held  = held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a keypad model closes row/column contacts, and a key-level
// model predicts codes, one event per press, scan rotation and release timing.
module tb_keypad_scanner;

  localparam int unsigned ROWS = 4;
  localparam int unsigned COLS = 4;
  localparam int unsigned DEB  = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [ROWS-1:0]      row_in;
  logic [COLS-1:0]      col_out;
  logic [3:0]           key_code;
  logic                 key_valid;
  logic                 key_ready;
  logic                 key_multi;
  logic                 key_held;
  logic [ROWS*COLS-1:0] keys;

  int                   checks   = 0;
  int                   errors   = 0;
  int                   hs_count = 0;
  logic [3:0]           hs_code  = '0;

  always #5 clk = ~clk;

  keypad_scanner #(
    .ROWS            (ROWS),
    .COLS            (COLS),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .slow_clk  (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_multi (key_multi),
    .key_held  (key_held)
  );

  // Keypad contact model: a row reads high when a pressed key sits on a driven column.
  always_comb begin
    row_in = '0;
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (keys[r*COLS+c] && col_out[c]) row_in[r] = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && key_valid && key_ready) begin
      hs_count <= hs_count + 1;
      hs_code  <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ROWS*COLS-1:0] key_bits(input logic [3:0] rm, input int c);
    logic [ROWS*COLS-1:0] k;
    k = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (rm[r]) k[r*COLS+c] = 1'b1;
    end
    return k;
  endfunction

  function automatic int exp_code(input logic [3:0] rm, input int c);
    for (int r = 0; r < ROWS; r++) begin
      if (rm[r]) return r * COLS + c;
    end
    return -1;
  endfunction

  function automatic int exp_multi(input logic [3:0] rm);
    return ($countones(rm) > 1) ? 1 : 0;
  endfunction

  task automatic wait_valid(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (key_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_released(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (!key_held) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_col(input logic [COLS-1:0] want, input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (col_out == want) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         ok;
    bit         seen;
    int         base;
    int         c;
    int         exp;
    logic [3:0] rm;

    rst_n     = 1'b0;
    key_ready = 1'b0;
    keys      = '0;
    #12;
    check("rst_col", 32'(col_out), 32'd1);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_multi", 32'(key_multi), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);

    // Idle scan: each column driven for three cycles, wrapping after the last.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 24; k++) begin
      check("idle_col", 32'(col_out), 32'(1 << ((k / 3) % COLS)));
      check("idle_valid", 32'(key_valid), 32'd0);
      @(negedge clk);
    end

    // Row 2 pressed while column 1 is driven.
    key_ready = 1'b1;
    wait_col(4'b0010, 20, ok);
    check("press_wait_col1", 32'(ok), 32'd1);
    keys = key_bits(4'b0100, 1);
    base = hs_count;
    wait_valid(40, ok);
    check("press_valid_seen", 32'(ok), 32'd1);
    check("press_code", 32'(key_code), 32'd9);
    check("press_multi", 32'(key_multi), 32'd0);
    check("press_held", 32'(key_held), 32'd1);
    @(negedge clk);
    check("press_pulse_end", 32'(key_valid), 32'd0);
    check("press_hs_count", 32'(hs_count - base), 32'd1);
    check("press_hs_code", 32'(hs_code), 32'd9);
    keys = '0;
    // Two synchroniser cycles plus DEB zero samples before scanning moves on.
    repeat (1 + DEB) @(negedge clk);
    check("rel_col_hold", 32'(col_out), 32'b0010);
    check("rel_held_hold", 32'(key_held), 32'd1);
    @(negedge clk);
    check("rel_col_next", 32'(col_out), 32'b0100);
    check("rel_held_drop", 32'(key_held), 32'd0);

    // Backpressure, with the key released while the code is still pending.
    key_ready = 1'b0;
    c    = int'($urandom_range(0, COLS - 1));
    rm   = 4'(1) << $urandom_range(0, ROWS - 1);
    exp  = exp_code(rm, c);
    keys = key_bits(rm, c);
    base = hs_count;
    wait_valid(40, ok);
    check("bp_valid_seen", 32'(ok), 32'd1);
    for (int i = 0; i < 20; i++) begin
      if (i == 5) keys = '0;
      check("bp_valid", 32'(key_valid), 32'd1);
      check("bp_code", 32'(key_code), 32'(exp));
      @(negedge clk);
    end
    check("bp_no_hs", 32'(hs_count - base), 32'd0);
    key_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_drop", 32'(key_valid), 32'd0);
    check("bp_hs_count", 32'(hs_count - base), 32'd1);
    check("bp_hs_code", 32'(hs_code), 32'(exp));
    wait_released(20, ok);
    check("bp_released", 32'(ok), 32'd1);

    // Bouncing contact: two cycles closed, two open, never long enough to commit.
    c    = int'($urandom_range(0, COLS - 1));
    rm   = 4'(1) << $urandom_range(0, ROWS - 1);
    base = hs_count;
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (i % 2 == 0) keys = keys ^ key_bits(rm, c);
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check("bounce_no_valid", 32'(seen), 32'd0);
    check("bounce_no_hs", 32'(hs_count - base), 32'd0);
    keys = key_bits(rm, c);
    wait_valid(40, ok);
    check("bounce_stable_valid", 32'(ok), 32'd1);
    check("bounce_stable_code", 32'(key_code), 32'(exp_code(rm, c)));
    repeat (30) @(negedge clk);
    check("bounce_one_key_held", 32'(hs_count - base), 32'd1);
    keys = '0;
    wait_released(20, ok);
    check("bounce_released", 32'(ok), 32'd1);
    check("bounce_one_key", 32'(hs_count - base), 32'd1);

    // Two rows on column 0.
    keys = key_bits(4'b1010, 0);
    wait_valid(40, ok);
    check("multi_valid_seen", 32'(ok), 32'd1);
    check("multi_code", 32'(key_code), 32'd4);
    check("multi_flag", 32'(key_multi), 32'd1);
    @(negedge clk);
    keys = '0;
    wait_released(20, ok);
    check("multi_released", 32'(ok), 32'd1);

    // Random presses with random acceptance delay and hold time.
    for (int n = 0; n < 8; n++) begin
      key_ready = 1'b0;
      c    = int'($urandom_range(0, COLS - 1));
      rm   = 4'($urandom_range(1, 15));
      keys = key_bits(rm, c);
      base = hs_count;
      wait_valid(40, ok);
      check("rnd_valid_seen", 32'(ok), 32'd1);
      check("rnd_code", 32'(key_code), 32'(exp_code(rm, c)));
      check("rnd_multi", 32'(key_multi), 32'(exp_multi(rm)));
      repeat ($urandom_range(0, 5)) begin
        @(negedge clk);
        check("rnd_valid_wait", 32'(key_valid), 32'd1);
      end
      key_ready = 1'b1;
      @(negedge clk);
      check("rnd_valid_drop", 32'(key_valid), 32'd0);
      repeat ($urandom_range(0, 30)) @(negedge clk);
      keys = '0;
      wait_released(20, ok);
      check("rnd_released", 32'(ok), 32'd1);
      check("rnd_one_key", 32'(hs_count - base), 32'd1);
      repeat (3) @(negedge clk);
    end

    // Asynchronous reset while a key is pending.
    key_ready = 1'b0;
    keys = key_bits(4'b0001, 2);
    wait_valid(40, ok);
    check("arst_valid_seen", 32'(ok), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(key_valid), 32'd0);
    check("arst_col", 32'(col_out), 32'd1);
    check("arst_held", 32'(key_held), 32'd0);
    check("arst_code", 32'(key_code), 32'd0);
    keys = '0;
    @(negedge clk);
    rst_n     = 1'b1;
    key_ready = 1'b1;
    base      = hs_count;
    seen      = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (key_valid) seen = 1'b1;
    end
    check("arst_no_valid", 32'(seen), 32'd0);
    check("arst_no_hs", 32'(hs_count - base), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Parametrised matrix-keypad scanner for the adder front end. It drives one-hot column strobes and synchronises the row inputs. It debounces both press and release with a programmable count, then presents an encoded key code to the downstream digit/operand logic over a valid/ready handshake. It supersedes the fixed 4×4, single-cycle press-detect controller, adding column scanning, key encoding, release debounce and backpressure.

## Interface
Parameters:
- ROWS, 4, number of keypad rows (2..8)
- COLS, 4, number of keypad columns (2..8)
- DEBOUNCE_CYCLES, 4, consecutive stable samples required for press and for release (1..255)

Ports:
- slow_clk  in  1  single scan clock
- rst_n  in  1  reset, asynchronous, active-low
- row_in  in  ROWS  raw keypad rows, active-high, asynchronous to slow_clk
- col_out  out  COLS  one-hot column drive, registered
- key_code  out  $clog2(ROWS*COLS)  row_idx*COLS + col_idx, stable while key_valid
- key_valid  out  1  encoded key available
- key_ready  in  1  consumer accepts key_code when key_valid && key_ready
- key_multi  out  1  more than one row bit was set in the latched pattern; valid with key_valid
- key_held  out  1  high in VALID and RELEASE states

## Operation
- row_in passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- Column dwell: each column is driven for DWELL=3 cycles. rs is evaluated only on the last dwell cycle, so settle time covers synchroniser latency.
- States:
  - SCAN: on a dwell-end with rs==0, rotate col_out left (bit COLS-1 wraps to bit 0) and restart dwell. On a dwell-end with rs!=0, latch rs into row_lat, hold the column, set cnt=1, and go to DEBOUNCE.
  - DEBOUNCE: each cycle, if rs==row_lat then cnt++. When cnt reaches DEBOUNCE_CYCLES, go to VALID and register key_code/key_multi. If rs!=row_lat, go to SCAN, advance to the next column, and leave key_valid low.
  - VALID: key_valid=1; key_code and key_multi are frozen. On key_valid&&key_ready, go to RELEASE; key_valid is low from the next cycle. Column remains held. Releasing the key in VALID does not drop key_valid: the press is already committed.
  - RELEASE: cnt counts consecutive cycles with rs==0; any rs!=0 clears cnt to 0. When cnt reaches DEBOUNCE_CYCLES, go to SCAN, advance the column, and restart dwell.
- Row priority: the lowest set bit of row_lat selects row_idx. key_multi = popcount(row_lat)>1.
- Only one key event per press. Autorepeat does not exist; holding a key never generates a second valid.
- DEBOUNCE_CYCLES=1: VALID is entered on the cycle after DEBOUNCE entry without an extra compare. Release needs one zero sample.

## Timing
- Reset values: col_out = 1 (column 0), key_valid=0, key_code=0, key_multi=0, key_held=0. State is SCAN, cnt=0, dwell=0, synchroniser flops are 0.
- Reset asserted mid-operation clears all of the above immediately (asynchronously). A pending key is discarded, not delivered.
- Input to decision: 2 cycles of synchroniser plus at most one dwell period.
- Press latency: key_valid rises DEBOUNCE_CYCLES edges after the DEBOUNCE-entry edge.
- key_ready high while key_valid is high: accepted on that edge. key_ready while key_valid is low is ignored.
- Full scan period: COLS*DWELL cycles.
- cnt is 8 bits and saturates; it never wraps.

## Structure
- Package keypad_pkg holds:
  - the state enum (SCAN, DEBOUNCE, VALID, RELEASE)
  - localparam DWELL=3
  - the counter width constant
- Sub-module sync_2ff holds the parametrised-width two-flop synchroniser. The scanner FSM, counters and encoder are all in keypad_scanner.

## Test plan
- Reset, no keys: col_out cycles 1→2→4→8→1 every 3 cycles; key_valid stays 0.
- 4×4, DEBOUNCE_CYCLES=4, press row 2 while col 1 is driven, key_ready=1: key_valid pulses one cycle with key_code=9 and key_multi=0. On release, after 4 zero samples, scanning resumes at col 2.
- Bounce: a row toggling every 2 cycles during DEBOUNCE returns the block to SCAN with no key_valid. A subsequent stable press yields exactly one key.
- Backpressure: key_ready=0 for 20 cycles keeps key_valid high and key_code constant. Releasing the key during that window still delivers it. Raising key_ready completes the transfer in one cycle.
- Multi-row: rows 1 and 3 pressed at col 0 give key_code=4 and key_multi=1.
- Async rst_n pulse while in VALID: key_valid drops immediately and col_out=1. Rows stay low after reset, so no key is reported.
